// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Serves one load/store per access/unlock handshake from the execution
// registers and exchanges whole lines with main memory.
module data_cache #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_LINES     = 4,
  parameter int LINE_WORDS    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             access,
  input  logic                             op,
  input  logic                             byte_op,
  input  logic [ADDRESS_WIDTH-1:0]         address,
  input  logic [WORD_WIDTH-1:0]            write_data,
  output logic [WORD_WIDTH-1:0]            read_data,
  output logic                             unlock,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDRESS_WIDTH-1:0]         mem_address,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] mem_write_line,
  input  logic [WORD_WIDTH*LINE_WORDS-1:0] mem_read_line,
  input  logic                             mem_ready
);

  localparam int BYTE_BITS     = $clog2(WORD_WIDTH / 8);
  localparam int WORD_OFF_BITS = $clog2(LINE_WORDS);
  localparam int INDEX_BITS    = $clog2(NUM_LINES);
  localparam int OFFSET_BITS   = BYTE_BITS + WORD_OFF_BITS;
  localparam int TAG_BITS      = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;

  typedef logic [WORD_WIDTH/8-1:0][7:0]           word_t;
  typedef logic [LINE_WORDS-1:0][WORD_WIDTH-1:0]  line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVICT   = 2'd1,
    FILL    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                state_r;
  line_t                 data_r  [NUM_LINES];
  logic [TAG_BITS-1:0]   tag_r   [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_r;
  logic [NUM_LINES-1:0]  dirty_r;

  logic [BYTE_BITS-1:0]     byte_off_s;
  logic [WORD_OFF_BITS-1:0] word_off_s;
  logic [INDEX_BITS-1:0]    index_s;
  logic [TAG_BITS-1:0]      tag_s;
  logic                     hit_s;
  logic                     victim_dirty_s;
  line_t                    base_line_s;
  line_t                    new_line_s;
  word_t                    sel_word_s;
  word_t                    new_word_s;
  logic [WORD_WIDTH-1:0]    load_value_s;

  assign byte_off_s     = address[0 +: BYTE_BITS];
  assign word_off_s     = address[BYTE_BITS +: WORD_OFF_BITS];
  assign index_s        = address[OFFSET_BITS +: INDEX_BITS];
  assign tag_s          = address[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign hit_s          = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign victim_dirty_s = valid_r[index_s] && dirty_r[index_s];

  // Datapath for the requested op: the source line is the fill data while
  // filling, otherwise the resident line; produces the merged store line and
  // the load result.
  always_comb begin
    if (state_r == FILL) begin
      base_line_s = line_t'(mem_read_line);
    end else begin
      base_line_s = data_r[index_s];
    end
    sel_word_s = base_line_s[word_off_s];
    new_word_s = sel_word_s;
    if (byte_op) begin
      new_word_s[byte_off_s] = write_data[7:0];
    end else begin
      new_word_s = write_data;
    end
    new_line_s             = base_line_s;
    new_line_s[word_off_s] = new_word_s;
    if (byte_op) begin
      load_value_s = {{(WORD_WIDTH-8){1'b0}}, sel_word_s[byte_off_s]};
    end else begin
      load_value_s = sel_word_s;
    end
  end

  // Controller: line state, handshake with the pipeline and line transfers
  // with main memory; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      valid_r        <= {NUM_LINES{1'b0}};
      dirty_r        <= {NUM_LINES{1'b0}};
      unlock         <= 1'b0;
      read_data      <= {WORD_WIDTH{1'b0}};
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_address    <= {ADDRESS_WIDTH{1'b0}};
      mem_write_line <= {(WORD_WIDTH*LINE_WORDS){1'b0}};
    end else begin
      unlock <= 1'b0;
      case (state_r)
        IDLE: begin
          if (access) begin
            if (hit_s) begin
              if (op) begin
                data_r[index_s]  <= new_line_s;
                dirty_r[index_s] <= 1'b1;
              end else begin
                read_data <= load_value_s;
              end
              unlock  <= 1'b1;
              state_r <= RESPOND;
            end else if (victim_dirty_s) begin
              mem_req        <= 1'b1;
              mem_we         <= 1'b1;
              mem_address    <= {tag_r[index_s], index_s, {OFFSET_BITS{1'b0}}};
              mem_write_line <= data_r[index_s];
              state_r        <= EVICT;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= 1'b0;
              mem_address <= {tag_s, index_s, {OFFSET_BITS{1'b0}}};
              state_r     <= FILL;
            end
          end
        end
        EVICT: begin
          if (mem_ready) begin
            // mem_req stays high; the fill follows without a gap.
            dirty_r[index_s] <= 1'b0;
            mem_we           <= 1'b0;
            mem_address      <= {tag_s, index_s, {OFFSET_BITS{1'b0}}};
            state_r          <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid_r[index_s] <= 1'b1;
            tag_r[index_s]   <= tag_s;
            dirty_r[index_s] <= op;
            if (op) begin
              data_r[index_s] <= new_line_s;
            end else begin
              data_r[index_s] <= base_line_s;
              read_data       <= load_value_s;
            end
            mem_req <= 1'b0;
            unlock  <= 1'b1;
            state_r <= RESPOND;
          end
        end
        RESPOND: begin
          state_r <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache that serves the memory stage. It is the responder side of the execution-register access/unlock handshake. It accepts one load or store from the execution registers, resolves it against its own lines or main memory, and returns a one-cycle `unlock` pulse that releases the pipeline lock. Its lower side talks to main memory one full line at a time.

## Interface
- `WORD_WIDTH`, 32, data word width in bits
- `ADDRESS_WIDTH`, 32, byte address width
- `NUM_LINES`, 4, number of cache lines (power of two)
- `LINE_WORDS`, 4, words per line (line = 128 bits at defaults)

Ports:
- `clk`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `access`  in  1  request valid; held high with stable operands until `unlock`
- `op`  in  1  0 = load, 1 = store
- `byte_op`  in  1  1 = byte access, 0 = word access
- `address`  in  ADDRESS_WIDTH  byte address (ALU result)
- `write_data`  in  WORD_WIDTH  store data; byte stores use bits [7:0]
- `read_data`  out  WORD_WIDTH  load result, valid while `unlock`=1
- `unlock`  out  1  one-cycle completion pulse
- `mem_req`  out  1  line transfer request to main memory
- `mem_we`  out  1  1 = line write-back, 0 = line fill
- `mem_address`  out  ADDRESS_WIDTH  line-aligned address (low log2(LINE_WORDS*4) bits zero)
- `mem_write_line`  out  WORD_WIDTH*LINE_WORDS  victim line data
- `mem_read_line`  in  WORD_WIDTH*LINE_WORDS  fill data, valid when `mem_ready`=1
- `mem_ready`  in  1  one-cycle completion pulse from main memory

## Operation
- Address split at defaults: [1:0] byte offset, [3:2] word offset, [5:4] index, [31:6] tag. Word accesses ignore [1:0]; misalignment is not trapped.
- Per line state: valid, dirty, tag, data. Reset clears all valid and dirty bits. Data and tag contents are don't-care after reset.
- FSM states and transitions:
  - IDLE: samples `access`. On a hit, perform the op and go to RESPOND. On a miss with a clean or invalid victim, go to FILL. On a miss with a dirty victim, go to EVICT.
  - EVICT: `mem_req`=1, `mem_we`=1, `mem_address` = {victim tag, index, 0}, `mem_write_line` = victim data. Stay until `mem_ready`, then go to FILL and clear dirty.
  - FILL: `mem_req`=1, `mem_we`=0, `mem_address` = {request tag, index, 0}. On `mem_ready`, install the line (valid=1, tag, data=`mem_read_line`) and perform the op on the new data in the same cycle, then go to RESPOND.
  - RESPOND: `unlock`=1 for exactly this cycle, then go to IDLE. `access` is ignored in this state.
- Load word: `read_data` = selected word. Load byte: `read_data` = selected byte, zero-extended.
- Store word: writes the full selected word. Store byte: writes only the byte lane at [1:0] from `write_data[7:0]`. Any store sets dirty=1.
- `read_data` is registered when the op is performed and holds until the next completed load. On stores it keeps its previous value.
- Requester rule: `access` must be low by the IDLE cycle following RESPOND. A high `access` in that cycle is treated as a new request.

## Timing
- Reset values: `unlock`=0, `read_data`=0, `mem_req`=0, `mem_we`=0, `mem_address`=0, state IDLE.
- Hit latency: `access` is sampled in IDLE at edge N, and `unlock` is high during cycle N+1.
- Clean miss latency: `mem_req` rises in cycle N+1. If `mem_ready` arrives in cycle M, `unlock` is high in cycle M+1.
- Dirty miss: the EVICT handshake completes first, then FILL starts the cycle after the eviction's `mem_ready`. `mem_req` stays high continuously across the EVICT→FILL transition, and `mem_we` drops in that cycle.
- `mem_req`, `mem_we` and `mem_address` are stable from assertion until `mem_ready` is sampled. `mem_ready` arriving outside EVICT or FILL is ignored.
- Reset mid-operation wins over everything else:
  - abort the transfer and drop `mem_req` next cycle;
  - a store in flight is lost, and no `unlock` is issued;
  - the requester is also reset.
- `unlock` is never high for two consecutive cycles.

## Test plan
- Reset, then load word at 0x40 with memory line = {0x44444444, 0x33333333, 0x22222222, 0x11111111} and `mem_ready` 3 cycles after `mem_req` -> exactly one fill with `mem_address`=0x40 and `mem_we`=0; `unlock` one cycle after `mem_ready`; `read_data`=0x11111111.
- Repeat load at 0x44 -> no `mem_req`; `unlock` at N+1; `read_data`=0x22222222.
- Byte store 0xAB at 0x46, then byte load at 0x46 and word load at 0x44 -> both hits; byte load returns 0x000000AB; word load returns 0x22AB2222.
- Load at 0x80, which maps to the same index as the dirty 0x40 line -> EVICT with `mem_address`=0x40, `mem_we`=1 and line word1=0x22AB2222, then FILL at 0x80; single `unlock`.
- Assert `reset` during FILL, before `mem_ready` -> `mem_req` low next cycle; no `unlock`; a following load at 0x40 misses because valid was cleared.
- Hold `access` high through RESPOND, deasserting it in the following IDLE cycle -> exactly one `unlock`; no second operation.
